// File: rtl/decode_stage.sv
// Instruction-decode stage: 8-entry register file with optional write-back
// bypass, immediate extension, destination select, load-use bubble insertion
// and a valid/ready guarded ID/EX output register.
module decode_stage #(
    parameter int          DATA_W   = 16,
    parameter logic [2:0]  LINK_REG = 3'd7,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       instr,
    input  logic [1:0]        ctrl_reg_dst,
    input  logic              ctrl_reg_write,
    input  logic              ctrl_mem_read,
    input  logic              ctrl_sext,
    input  logic              wb_en,
    input  logic [2:0]        wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [DATA_W-1:0] out_imm5,
    output logic [DATA_W-1:0] out_imm8,
    output logic [DATA_W-1:0] out_imm11,
    output logic [2:0]        out_dst,
    output logic              out_reg_write,
    output logic              out_mem_read,
    output logic              hazard
);

    logic [DATA_W-1:0] rf_q [8];
    logic [2:0]        rs;
    logic [2:0]        rt;
    logic [2:0]        dst;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;
    logic [DATA_W-1:0] imm5;
    logic [DATA_W-1:0] imm8;
    logic [DATA_W-1:0] imm11;
    logic              accept;
    logic              unused_instr;

    assign rs = instr[10:8];
    assign rt = instr[7:5];
    assign unused_instr = ^instr[15:11];

    // Register file; write-back commits regardless of flush or stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wb_en) begin
            rf_q[wb_reg] <= wb_data;
        end
    end

    // Operand reads, forwarding a same-cycle write-back when enabled.
    always_comb begin
        rd_a = rf_q[rs];
        rd_b = rf_q[rt];
        if (BYPASS && wb_en && (wb_reg == rs)) begin
            rd_a = wb_data;
        end
        if (BYPASS && wb_en && (wb_reg == rt)) begin
            rd_b = wb_data;
        end
    end

    // Immediate extension and destination select.
    always_comb begin
        imm5  = {{(DATA_W-5){ctrl_sext & instr[4]}}, instr[4:0]};
        imm8  = {{(DATA_W-8){ctrl_sext & instr[7]}}, instr[7:0]};
        imm11 = {{(DATA_W-11){instr[10]}}, instr[10:0]};
        case (ctrl_reg_dst)
            2'd0:    dst = instr[4:2];
            2'd1:    dst = instr[7:5];
            2'd2:    dst = instr[10:8];
            default: dst = LINK_REG;
        endcase
    end

    // Load-use detection compares both source fields even if one is unused.
    always_comb begin
        hazard   = in_valid & out_valid & out_mem_read & out_reg_write &
                   ((out_dst == rs) | (out_dst == rt));
        in_ready = (!out_valid | out_ready) & !hazard & !flush;
        accept   = in_valid & in_ready;
    end

    // ID/EX register: flush kills, accept captures, drain emits a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid     <= 1'b0;
            out_a         <= '0;
            out_b         <= '0;
            out_imm5      <= '0;
            out_imm8      <= '0;
            out_imm11     <= '0;
            out_dst       <= '0;
            out_reg_write <= 1'b0;
            out_mem_read  <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid     <= 1'b1;
            out_a         <= rd_a;
            out_b         <= rd_b;
            out_imm5      <= imm5;
            out_imm8      <= imm8;
            out_imm11     <= imm11;
            out_dst       <= dst;
            out_reg_write <= ctrl_reg_write;
            out_mem_read  <= ctrl_mem_read;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage; a second instance with forwarding disabled
// shares all inputs so the no-bypass read path can be compared side by side.
module tb_decode_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] instr;
    logic [1:0]  ctrl_reg_dst;
    logic        ctrl_reg_write;
    logic        ctrl_mem_read;
    logic        ctrl_sext;
    logic        wb_en;
    logic [2:0]  wb_reg;
    logic [15:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_a, out_b, out_imm5, out_imm8, out_imm11;
    logic [2:0]  out_dst;
    logic        out_reg_write, out_mem_read, hazard;

    logic        nb_in_ready, nb_out_valid, nb_reg_write, nb_mem_read, nb_hazard;
    logic [15:0] nb_a, nb_b, nb_imm5, nb_imm8, nb_imm11;
    logic [2:0]  nb_dst;

    int errors = 0;
    int checks = 0;

    decode_stage #(.DATA_W(16), .LINK_REG(3'd7), .BYPASS(1'b1)) u_dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .ctrl_reg_dst(ctrl_reg_dst), .ctrl_reg_write(ctrl_reg_write),
        .ctrl_mem_read(ctrl_mem_read), .ctrl_sext(ctrl_sext), .wb_en(wb_en),
        .wb_reg(wb_reg), .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_imm5(out_imm5), .out_imm8(out_imm8),
        .out_imm11(out_imm11), .out_dst(out_dst), .out_reg_write(out_reg_write),
        .out_mem_read(out_mem_read), .hazard(hazard)
    );

    decode_stage #(.DATA_W(16), .LINK_REG(3'd7), .BYPASS(1'b0)) u_nb (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(nb_in_ready),
        .instr(instr), .ctrl_reg_dst(ctrl_reg_dst), .ctrl_reg_write(ctrl_reg_write),
        .ctrl_mem_read(ctrl_mem_read), .ctrl_sext(ctrl_sext), .wb_en(wb_en),
        .wb_reg(wb_reg), .wb_data(wb_data), .out_valid(nb_out_valid), .out_ready(out_ready),
        .out_a(nb_a), .out_b(nb_b), .out_imm5(nb_imm5), .out_imm8(nb_imm8),
        .out_imm11(nb_imm11), .out_dst(nb_dst), .out_reg_write(nb_reg_write),
        .out_mem_read(nb_mem_read), .hazard(nb_hazard)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [2:0] r, input logic [15:0] d);
        wb_en   = 1'b1;
        wb_reg  = r;
        wb_data = d;
        step();
        wb_en   = 1'b0;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; instr = '0;
        ctrl_reg_dst = 2'd0; ctrl_reg_write = 1'b0; ctrl_mem_read = 1'b0;
        ctrl_sext = 1'b0; wb_en = 1'b0; wb_reg = '0; wb_data = '0; out_ready = 1'b1;
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_a", out_a, 0);
        rst = 1'b1;
        step();

        wb_write(3'd1, 16'h1111);
        wb_write(3'd2, 16'h2222);
        wb_write(3'd3, 16'h1234);
        wb_write(3'd5, 16'h5555);

        // Bypass: write r3 while accepting an instruction reading rs=3
        instr = 16'h0300; in_valid = 1'b1;
        wb_en = 1'b1; wb_reg = 3'd3; wb_data = 16'hBEEF;
        #1;
        chk("byp_in_ready", in_ready, 1);
        step();
        wb_en = 1'b0;
        chk("byp_out_valid", out_valid, 1);
        chk("byp_out_a", out_a, 16'hBEEF);
        chk("nobyp_out_a", nb_a, 16'h1234);
        chk("byp_out_b", out_b, 16'h0000);

        // Immediates and link destination
        instr = 16'h40F5; ctrl_sext = 1'b1; ctrl_reg_dst = 2'd3;
        step();
        chk("imm5_s", out_imm5, 16'hFFF5);
        chk("imm8_s", out_imm8, 16'hFFF5);
        chk("imm11_s", out_imm11, 16'h00F5);
        chk("dst_link", out_dst, 3'd7);
        ctrl_sext = 1'b0; ctrl_reg_dst = 2'd0;
        step();
        chk("imm5_z", out_imm5, 16'h0015);
        chk("imm8_z", out_imm8, 16'h00F5);
        chk("imm11_z", out_imm11, 16'h00F5);
        chk("dst_rd", out_dst, 3'd5);
        instr = 16'h0480; ctrl_sext = 1'b1; ctrl_reg_dst = 2'd2;
        step();
        chk("imm11_neg", out_imm11, 16'hFC80);
        chk("imm8_neg", out_imm8, 16'hFF80);
        chk("dst_rs", out_dst, 3'd4);
        ctrl_sext = 1'b0;

        // Load-use: load to r2, then consumer with rt=2
        instr = 16'h0008; ctrl_reg_dst = 2'd0; ctrl_mem_read = 1'b1; ctrl_reg_write = 1'b1;
        step();
        chk("ld_valid", out_valid, 1);
        chk("ld_dst", out_dst, 3'd2);
        chk("ld_mem_read", out_mem_read, 1);
        instr = 16'h0040; ctrl_mem_read = 1'b0;
        #1;
        chk("lu_hazard", hazard, 1);
        chk("lu_in_ready", in_ready, 0);
        step();
        chk("lu_bubble", out_valid, 0);
        chk("lu_hazard_clr", hazard, 0);
        chk("lu_in_ready2", in_ready, 1);
        step();
        chk("lu_cons_valid", out_valid, 1);
        chk("lu_cons_b", out_b, 16'h2222);
        chk("lu_cons_dst", out_dst, 3'd0);
        chk("lu_cons_mr", out_mem_read, 0);

        // Backpressure for 4 cycles with a pending instruction
        out_ready = 1'b0; instr = 16'h0500; ctrl_reg_dst = 2'd2; ctrl_reg_write = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("bp_in_ready", in_ready, 0);
            step();
            chk("bp_valid", out_valid, 1);
            chk("bp_b", out_b, 16'h2222);
            chk("bp_dst", out_dst, 3'd0);
            chk("bp_reg_write", out_reg_write, 1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 1);
        step();
        chk("bp_next_a", out_a, 16'h5555);
        chk("bp_next_dst", out_dst, 3'd5);
        chk("bp_next_rw", out_reg_write, 0);

        // Flush with pending input, valid output and a concurrent write-back
        flush = 1'b1; instr = 16'h0100; ctrl_reg_dst = 2'd0;
        wb_en = 1'b1; wb_reg = 3'd6; wb_data = 16'h6666;
        #1;
        chk("fl_in_ready", in_ready, 0);
        step();
        flush = 1'b0; wb_en = 1'b0;
        chk("fl_valid", out_valid, 0);
        instr = 16'h0600;
        step();
        chk("fl_wb_commit", out_a, 16'h6666);
        chk("fl_wb_commit_nb", nb_a, 16'h6666);
        chk("fl_after_valid", out_valid, 1);

        // Mid-stream reset
        in_valid = 1'b0; out_ready = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("mrst_valid", out_valid, 0);
        chk("mrst_a", out_a, 0);
        chk("mrst_dst", out_dst, 0);
        chk("mrst_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b1;
        instr = 16'h0500; in_valid = 1'b1; out_ready = 1'b1;
        step();
        chk("mrst_r5_valid", out_valid, 1);
        chk("mrst_r5", out_a, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
